// File: rtl/jt6295_rom_arb_pkg.sv
// rtl/jt6295_rom_arb_pkg.sv - shared FSM encoding and slot-index width helper for the JT6295 ROM arbiter
package jt6295_rom_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_WAIT   = 2'd2,
      ST_ACK    = 2'd3
   } arb_state_t;

   localparam int TOUT_W = 8;

   // Width of an owner/pointer index; voices decode the owner with the same value.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/jt6295_rr_pick.sv
// rtl/jt6295_rr_pick.sv - combinational circular priority picker starting at a rotating pointer
module jt6295_rr_pick #(
   parameter int N  = 4,
   parameter int PW = 3
) (
   input  logic [N-1:0]  i_req,
   input  logic [PW-1:0] i_ptr,
   output logic [N-1:0]  o_grant,
   output logic [PW-1:0] o_idx,
   output logic          o_any
);

   logic [2*N-1:0] w_dbl;
   logic [PW:0]    w_slot;

   // Rotating a doubled copy puts the pointer slot at bit 0; the lowest set bit wins.
   always_comb begin
      w_dbl  = {i_req, i_req} >> i_ptr;
      w_slot = '0;
      o_idx  = '0;
      o_any  = 1'b0;
      for (int j = N - 1; j >= 0; j--) begin
         if (w_dbl[j]) begin
            w_slot = {1'b0, i_ptr} + (PW+1)'(j);
            if (w_slot >= (PW+1)'(N)) w_slot = w_slot - (PW+1)'(N);
            o_idx = w_slot[PW-1:0];
            o_any = 1'b1;
         end
      end
      o_grant = o_any ? (N'(1) << o_idx) : '0;
   end

endmodule

// File: rtl/jt6295_rom_arb.sv
// rtl/jt6295_rom_arb.sv - serialises control and voice byte reads onto one ROM port with round-robin and timeout
import jt6295_rom_arb_pkg::*;

module jt6295_rom_arb #(
   parameter int NCH       = 4,
   parameter int AW        = 18,
   parameter int CTRL_PRIO = 1,
   parameter int TOUT      = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ctrl_req,
   input  logic [AW-1:0]     ctrl_addr,
   output logic              ctrl_ack,
   input  logic [NCH-1:0]    ch_req,
   input  logic [NCH*AW-1:0] ch_addr,
   output logic [NCH-1:0]    ch_ack,
   output logic [7:0]        dout,
   output logic [AW-1:0]     rom_addr,
   output logic              rom_cs,
   input  logic [7:0]        rom_data,
   input  logic              rom_ok,
   output logic              busy,
   output logic              tout_err
);

   localparam int NS = (CTRL_PRIO != 0) ? NCH : NCH + 1;
   localparam int SW = clog2(NCH + 1);

   arb_state_t        r_state, w_next;
   logic [AW-1:0]     r_rom_addr;
   logic              r_rom_cs;
   logic [7:0]        r_dout;
   logic              r_tout_err;
   logic [TOUT_W-1:0] r_cnt;
   logic [SW-1:0]     r_ptr;
   logic [NCH-1:0]    r_own_ch;
   logic              r_own_ctrl;
   logic [SW-1:0]     r_own_idx;

   logic [NS-1:0]     w_slot_req, w_grant;
   logic [SW-1:0]     w_idx, w_win_idx;
   logic              w_any, w_win_any, w_win_ctrl, w_tout;
   logic [NCH-1:0]    w_win_ch;
   logic [AW-1:0]     w_win_addr;

   jt6295_rr_pick #(.N(NS), .PW(SW)) u_pick (
      .i_req   (w_slot_req),
      .i_ptr   (r_ptr),
      .o_grant (w_grant),
      .o_idx   (w_idx),
      .o_any   (w_any)
   );

   // Control owns index NCH in both modes so ack decode and pointer wrap stay uniform.
   generate
      if (CTRL_PRIO != 0) begin : g_prio
         assign w_slot_req = ch_req;
         assign w_win_ctrl = ctrl_req;
         assign w_win_ch   = ctrl_req ? '0 : w_grant;
         assign w_win_idx  = ctrl_req ? SW'(NCH) : w_idx;
         assign w_win_any  = ctrl_req | w_any;
      end else begin : g_rot
         assign w_slot_req = {ctrl_req, ch_req};
         assign w_win_ctrl = w_grant[NCH];
         assign w_win_ch   = w_grant[NCH-1:0];
         assign w_win_idx  = w_idx;
         assign w_win_any  = w_any;
      end
   endgenerate

   always_comb begin
      w_win_addr = ctrl_addr;
      for (int k = 0; k < NCH; k++) begin
         if (w_win_ch[k]) w_win_addr = ch_addr[k*AW +: AW];
      end
   end

   assign w_tout = (r_cnt == TOUT_W'(TOUT));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:   if (w_win_any) w_next = ST_SETTLE;
         ST_SETTLE: w_next = ST_WAIT;
         ST_WAIT:   if (rom_ok || w_tout) w_next = ST_ACK;
         ST_ACK:    w_next = ST_IDLE;
         default:   w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rom_addr <= '0;
         r_rom_cs   <= 1'b0;
         r_dout     <= 8'h00;
         r_tout_err <= 1'b0;
         r_cnt      <= '0;
         r_ptr      <= '0;
         r_own_ch   <= '0;
         r_own_ctrl <= 1'b0;
         r_own_idx  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: if (w_win_any) begin
               r_rom_addr <= w_win_addr;
               r_rom_cs   <= 1'b1;
               r_cnt      <= '0;
               r_own_ch   <= w_win_ch;
               r_own_ctrl <= w_win_ctrl;
               r_own_idx  <= w_win_idx;
            end
            ST_WAIT: begin
               if (rom_ok) begin
                  r_dout   <= rom_data;
                  r_rom_cs <= 1'b0;
               end else if (w_tout) begin
                  r_dout     <= 8'h00;
                  r_tout_err <= 1'b1;
                  r_rom_cs   <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + TOUT_W'(1);
               end
            end
            ST_ACK: begin
               // A prioritised control grant leaves the voice rotation untouched.
               if (!(r_own_ctrl && CTRL_PRIO != 0)) begin
                  if (r_own_idx == SW'(NS - 1)) r_ptr <= '0;
                  else                          r_ptr <= r_own_idx + SW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign ch_ack   = (r_state == ST_ACK) ? r_own_ch : '0;
   assign ctrl_ack = (r_state == ST_ACK) && r_own_ctrl;
   assign busy     = (r_state != ST_IDLE);
   assign rom_addr = r_rom_addr;
   assign rom_cs   = r_rom_cs;
   assign dout     = r_dout;
   assign tout_err = r_tout_err;

endmodule

// File: tb/tb_jt6295_rom_arb.sv
// tb/tb_jt6295_rom_arb.sv - randomized transaction-level check of jt6295_rom_arb in both control modes
module tb_jt6295_rom_arb;

   localparam int NCH  = 4;
   localparam int AW   = 18;
   localparam int TOUT = 8;

   logic              clk, rst;
   logic              ctrl_req  [2];
   logic [AW-1:0]     ctrl_addr [2];
   logic              ctrl_ack  [2];
   logic [NCH-1:0]    ch_req    [2];
   logic [NCH*AW-1:0] ch_addr   [2];
   logic [NCH-1:0]    ch_ack    [2];
   logic [7:0]        dout      [2];
   logic [AW-1:0]     rom_addr  [2];
   logic              rom_cs    [2];
   logic [7:0]        rom_data  [2];
   logic              rom_ok    [2];
   logic              busy      [2];
   logic              tout_err  [2];

   int          n_chk, n_fail;
   int          m_ptr  [2];
   logic [7:0]  m_dout [2];
   logic        m_terr [2];

   function automatic logic [7:0] romf(input logic [AW-1:0] a);
      return a[7:0] ^ a[15:8] ^ {6'b0, a[17:16]} ^ 8'hA5;
   endfunction

   // Unit 0 gives control absolute priority, unit 1 rotates it as slot NCH.
   for (genvar g = 0; g < 2; g++) begin : g_dut
      assign rom_data[g] = romf(rom_addr[g]);
      jt6295_rom_arb #(.NCH(NCH), .AW(AW), .CTRL_PRIO(g == 0 ? 1 : 0), .TOUT(TOUT)) u_dut (
         .clk(clk), .rst(rst),
         .ctrl_req(ctrl_req[g]), .ctrl_addr(ctrl_addr[g]), .ctrl_ack(ctrl_ack[g]),
         .ch_req(ch_req[g]), .ch_addr(ch_addr[g]), .ch_ack(ch_ack[g]),
         .dout(dout[g]), .rom_addr(rom_addr[g]), .rom_cs(rom_cs[g]),
         .rom_data(rom_data[g]), .rom_ok(rom_ok[g]),
         .busy(busy[g]), .tout_err(tout_err[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      for (int u = 0; u < 2; u++) begin
         m_ptr[u] = 0; m_dout[u] = 8'h00; m_terr[u] = 1'b0;
         ctrl_req[u] = 1'b0; ch_req[u] = '0; rom_ok[u] = 1'b0;
      end
   endtask

   // Next winner: control first in priority mode, else first pending slot from the pointer.
   function automatic int pick(input int u);
      int n;
      n = (u == 0) ? NCH : NCH + 1;
      if (u == 0 && ctrl_req[0]) return NCH;
      for (int i = 0; i < n; i++) begin
         int s;
         s = (m_ptr[u] + i) % n;
         if (s == NCH ? ctrl_req[u] : ch_req[u][s]) return s;
      end
      return -1;
   endfunction

   task automatic feed(input int u, input int pct_ch, input int pct_ctrl);
      for (int k = 0; k < NCH; k++) begin
         if (!ch_req[u][k] && $urandom_range(99) < pct_ch) begin
            ch_req[u][k] = 1'b1;
            ch_addr[u][k*AW +: AW] = AW'($urandom);
         end
      end
      if (!ctrl_req[u] && $urandom_range(99) < pct_ctrl) begin
         ctrl_req[u]  = 1'b1;
         ctrl_addr[u] = AW'($urandom);
      end
   endtask

   // One IDLE cycle plus, if anything is pending, a full transaction with rom_ok first high d cycles into WAIT.
   task automatic txn(input int u, input int d, input logic stale, input int pct_ch, input int pct_ctrl);
      int w, n, ack_at;
      logic [AW-1:0]  ea;
      logic [7:0]     ed;
      logic [NCH-1:0] ech;
      n = (u == 0) ? NCH : NCH + 1;
      ea = '0;
      check("idle_busy", busy[u], 1'b0);
      check("idle_cs", rom_cs[u], 1'b0);
      check("idle_ack", {ctrl_ack[u], ch_ack[u]}, '0);
      check("dout_hold", dout[u], m_dout[u]);
      check("idle_terr", tout_err[u], m_terr[u]);
      feed(u, pct_ch, pct_ctrl);
      w = pick(u);
      rom_ok[u] = 1'($urandom);
      if (w >= 0) ea = (w == NCH) ? ctrl_addr[u] : ch_addr[u][w*AW +: AW];
      step();
      if (w < 0) return;
      if (!(u == 0 && w == NCH)) m_ptr[u] = (w + 1) % n;
      check("settle_busy", busy[u], 1'b1);
      check("settle_cs", rom_cs[u], 1'b1);
      check("settle_addr", rom_addr[u], ea);
      check("settle_ack", {ctrl_ack[u], ch_ack[u]}, '0);
      rom_ok[u] = stale;
      if (w < NCH) ch_addr[u][w*AW +: AW] = AW'($urandom);
      ack_at = 3 + ((d > TOUT) ? TOUT : d);
      for (int c = 2; c < ack_at; c++) begin
         step();
         check("wait_busy", busy[u], 1'b1);
         check("wait_cs", rom_cs[u], 1'b1);
         check("wait_addr", rom_addr[u], ea);
         check("wait_ack", {ctrl_ack[u], ch_ack[u]}, '0);
         rom_ok[u] = (c - 2 >= d);
      end
      step();
      ed = (d > TOUT) ? 8'h00 : romf(ea);
      if (d > TOUT) m_terr[u] = 1'b1;
      m_dout[u] = ed;
      ech = (w < NCH) ? (NCH'(1) << w) : '0;
      check("ack_ch", ch_ack[u], ech);
      check("ack_ctrl", ctrl_ack[u], w == NCH);
      check("ack_dout", dout[u], ed);
      check("ack_terr", tout_err[u], m_terr[u]);
      rom_ok[u] = 1'($urandom);
      step();
      if (w == NCH) ctrl_req[u] = 1'b0;
      else          ch_req[u][w] = 1'b0;
   endtask

   task automatic drain(input int u);
      for (int i = 0; i < NCH + 2; i++) txn(u, 0, 1'b1, 0, 0);
   endtask

   function automatic int rnd_d();
      int r;
      r = $urandom_range(9);
      if (r < 4) return 0;
      if (r < 8) return $urandom_range(TOUT, 1);
      return (r == 8) ? TOUT + 1 : 99;
   endfunction

   initial begin
      n_chk = 0; n_fail = 0;
      rst = 1'b1;
      model_reset();
      for (int u = 0; u < 2; u++) begin
         ctrl_addr[u] = '0; ch_addr[u] = '0;
      end
      repeat (3) step();
      for (int u = 0; u < 2; u++) begin
         check("rst_busy", busy[u], 1'b0);
         check("rst_cs", rom_cs[u], 1'b0);
         check("rst_addr", rom_addr[u], '0);
         check("rst_ack", {ctrl_ack[u], ch_ack[u]}, '0);
         check("rst_dout", dout[u], 8'h00);
         check("rst_terr", tout_err[u], 1'b0);
      end
      rst = 1'b0;
      step();

      ch_req[0] = 4'b0100;
      ch_addr[0][2*AW +: AW] = 18'h01234;
      txn(0, 0, 1'b1, 0, 0);
      for (int i = 0; i < 12; i++) txn(0, 0, 1'b1, 100, 0);
      for (int i = 0; i < 6; i++)  txn(0, 0, 1'b1, 100, 100);
      for (int i = 0; i < 6; i++)  txn(0, 0, 1'b1, 100, 0);
      txn(0, 5, 1'b1, 100, 0);
      txn(0, 99, 1'b0, 100, 0);
      for (int i = 0; i < 4; i++)  txn(0, 0, 1'b1, 100, 0);
      for (int i = 0; i < 60; i++) txn(0, rnd_d(), 1'($urandom), $urandom_range(100), $urandom_range(30));
      drain(0);

      ch_req[0] = 4'b0100;
      txn(0, 0, 1'b1, 0, 0);
      ch_req[0] = 4'b1010;
      rom_ok[0] = 1'b0;
      step();
      check("abort_cs", rom_cs[0], 1'b1);
      step();
      rst = 1'b1;
      #1;
      check("abort_cs0", rom_cs[0], 1'b0);
      check("abort_busy", busy[0], 1'b0);
      check("abort_ack", {ctrl_ack[0], ch_ack[0]}, '0);
      check("abort_addr", rom_addr[0], '0);
      check("abort_dout", dout[0], 8'h00);
      check("abort_terr", tout_err[0], 1'b0);
      model_reset();
      for (int i = 0; i < 3; i++) begin
         step();
         check("abort_noack", {ctrl_ack[0], ch_ack[0]}, '0);
      end
      rst = 1'b0;
      ch_req[0] = 4'b1010;
      txn(0, 0, 1'b1, 0, 0);
      drain(0);

      for (int i = 0; i < 10; i++) txn(1, 0, 1'b1, 100, 100);
      for (int i = 0; i < 60; i++) txn(1, rnd_d(), 1'($urandom), $urandom_range(100), $urandom_range(60));
      drain(1);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/jt6295_rom_arb.md
# jt6295_rom_arb

ROM access arbiter for the JT6295 ADPCM core. A single 8-bit sample ROM port is shared between the command/header fetch path and NCH ADPCM voice fetchers. It sits between the voice engines and the external ROM interface. It serialises byte reads with a req/ack handshake, round-robin fairness and a ROM timeout. The voice engines feed their decoded samples to the channel accumulator, so starving any voice shows up directly as audible dropouts.

## Interface
Parameters:
- NCH, 4, number of voice requesters (2..8)
- AW, 18, ROM byte address width
- CTRL_PRIO, 1, 1 = control path has absolute priority; 0 = control joins the rotation as slot NCH
- TOUT, 255, max cycles to wait for rom_ok before forced completion (8-bit counter)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- ctrl_req  in  1  control/header fetch request, held until ctrl_ack
- ctrl_addr  in  AW  control fetch address, stable while ctrl_req
- ctrl_ack  out  1  one-cycle completion pulse for control
- ch_req  in  NCH  per-voice request, held until matching ch_ack bit
- ch_addr  in  NCH*AW  per-voice address; voice k at [k*AW +: AW]
- ch_ack  out  NCH  one-hot one-cycle completion pulse
- dout  out  8  fetched byte; valid in ack cycle, held until next completion
- rom_addr  out  AW  ROM address
- rom_cs  out  1  ROM read strobe
- rom_data  in  8  ROM data
- rom_ok  in  1  ROM data valid for current rom_addr
- busy  out  1  high in any state other than IDLE
- tout_err  out  1  sticky; set on any timeout

## Operation
- FSM states: IDLE, SETTLE, WAIT, ACK.
- IDLE → SETTLE when any request is present. In that transition the block picks the winner, registers its address into rom_addr and its identity as owner, sets rom_cs=1 and clears the timeout counter.
- SETTLE lasts one cycle. rom_ok is ignored there to reject a stale ok from the previous address. Then → WAIT.
- WAIT, on rom_ok=1: latch rom_data into dout and go → ACK.
- WAIT, with no rom_ok: increment the counter. When it reaches TOUT, dout←0x00, tout_err←1 and go → ACK.
- ACK: rom_cs←0, the owner's ack bit is high for exactly this cycle, then → IDLE. The round-robin pointer advances to owner+1 mod NCH (or mod NCH+1 when CTRL_PRIO=0).
- Selection with CTRL_PRIO=1: ctrl_req wins if set. Otherwise the first set ch_req at or after the pointer wins.
- Selection with CTRL_PRIO=0: the same circular search over NCH+1 slots, with control at index NCH. In this mode the pointer only advances past control slots in rotation order.
- Requesters clear req on the edge where they sample ack=1, so IDLE never re-serves the same request.
- A req dropped mid-transaction does not abort it: the transaction completes and ack still pulses.
- Addresses are sampled only on IDLE→SETTLE. Later ch_addr/ctrl_addr changes do not affect the transaction in flight.
- tout_err is cleared only by rst.

## Timing
- Reset values: state IDLE, rom_cs=0, rom_addr=0, all acks 0, dout=0x00, busy=0, tout_err=0, pointer 0.
- With rom_ok held high, req is seen in cycle 0 and the cycles run as follows:
  - cycle 1: SETTLE, rom_cs=1
  - cycle 2: WAIT, data latched
  - cycle 3: ACK, ack=1, dout valid
  - cycle 4: IDLE
- Throughput is at most one byte per 4 cycles when requests are back-to-back.
- On timeout, ack occurs in cycle 2+TOUT+1.
- Reset asserted mid-transaction returns everything to reset values immediately. No ack is produced for the aborted request.

## Structure
- State encodings and the slot-index width, computed by the function clog2(NCH+1), go in the shared jt6295 defines header, so the voice engines and the control block decode the owner consistently.
- One sub-module: jt6295_rr_pick. It is a combinational circular priority picker taking a request vector and the pointer, and returning a one-hot grant plus the encoded winner.
- The FSM, counter and datapath registers stay in jt6295_rom_arb.

## Test plan
- Single request, rom_ok tied 1: ch_req[2]=1 with addr 0x01234 → rom_addr=0x01234 in cycle 1, ch_ack=4'b0100 in cycle 3 only, dout=rom_data.
- All four voices request continuously: grants go 0,1,2,3,0… and each voice gets exactly one ack per 16 cycles.
- CTRL_PRIO=1, ctrl_req and all ch_req held: control is served on every transaction. Release ctrl and voices resume from the pointer left by the last voice grant.
- Stale ok: rom_ok high only in the SETTLE cycle and then low for 5 cycles before rising → data latched from the later ok, ack 1 cycle after.
- rom_ok never asserted, TOUT=8: ack in cycle 11, dout=0x00, tout_err=1 and staying set through subsequent normal transactions.
- Assert rst during WAIT: rom_cs, busy and acks drop immediately, no ack follows. A new request after reset is served from pointer 0.
